// File: rtl/eth_frame_detector_mem_arbiter.sv
// Arbitrates one single-port script BRAM between the AXI memory port and the core fetch port.
// Core fetches win, but an AXI request blocked for C_MAX_WAIT cycles is forced through.
module eth_frame_detector_mem_arbiter #(
    parameter int unsigned C_AXI_WIDTH      = 32,
    parameter int unsigned C_MEM_ADDR_WIDTH = 14,
    parameter int unsigned C_MEM_LATENCY    = 2,
    parameter int unsigned C_MAX_WAIT       = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        srst,
    input  logic                        mem_req,
    input  logic [C_MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                        mem_wenable,
    input  logic [C_AXI_WIDTH-1:0]      mem_wdata,
    output logic [C_AXI_WIDTH-1:0]      mem_rdata,
    output logic                        mem_ack,
    input  logic                        core_req,
    input  logic [C_MEM_ADDR_WIDTH-1:0] core_addr,
    output logic                        core_grant,
    output logic [C_AXI_WIDTH-1:0]      core_rdata,
    output logic                        core_rvalid,
    output logic                        bram_en,
    output logic                        bram_we,
    output logic [C_MEM_ADDR_WIDTH-1:0] bram_addr,
    output logic [C_AXI_WIDTH-1:0]      bram_wdata,
    input  logic [C_AXI_WIDTH-1:0]      bram_rdata,
    output logic [31:0]                 contention_count
);

    localparam int unsigned LatW  = 3;
    localparam int unsigned WaitW = 8;
    localparam logic [LatW-1:0]  LatInit = LatW'(C_MEM_LATENCY);
    localparam logic [WaitW-1:0] MaxWait = WaitW'(C_MAX_WAIT);

    typedef enum logic [2:0] {
        StIdle,
        StReadWait,
        StWriteAck,
        StAck,
        StHold
    } state_e;

    state_e                   state_q;
    logic [WaitW-1:0]         wait_q;
    logic [LatW-1:0]          lat_q;
    logic [C_MEM_LATENCY-1:0] vld_q;
    logic [C_AXI_WIDTH-1:0]   mem_rdata_q;
    logic                     mem_ack_q;
    logic [31:0]              contention_q;

    logic is_idle;
    logic wait_full;
    logic axi_issue;
    logic sync_rst;

    assign sync_rst  = ~rst_n | srst;
    assign is_idle   = (state_q == StIdle);
    assign wait_full = (wait_q == MaxWait);
    assign axi_issue = is_idle & mem_req & (~core_req | wait_full);

    assign core_grant = core_req & ~(is_idle & mem_req & wait_full);

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = mem_addr;
        if (core_grant) begin
            bram_en   = 1'b1;
            bram_addr = core_addr;
        end else if (axi_issue) begin
            bram_en   = 1'b1;
            bram_we   = mem_wenable;
            bram_addr = mem_addr;
        end
    end

    assign bram_wdata = mem_wdata;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            lat_q        <= '0;
            mem_rdata_q  <= '0;
            mem_ack_q    <= 1'b0;
            contention_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (axi_issue) begin
                        wait_q <= '0;
                        lat_q  <= LatInit;
                        if (mem_wenable) begin
                            state_q   <= StWriteAck;
                            mem_ack_q <= 1'b1;
                        end else begin
                            state_q <= StReadWait;
                        end
                    end else if (!mem_req) begin
                        wait_q <= '0;
                    end else if (core_req) begin
                        if (!wait_full) begin
                            wait_q <= wait_q + WaitW'(1);
                        end
                        contention_q <= contention_q + 32'd1;
                    end
                end
                StReadWait: begin
                    lat_q <= lat_q - LatW'(1);
                    // Last decrement lands on the cycle the BRAM presents the AXI word.
                    if (lat_q == LatW'(1)) begin
                        mem_rdata_q <= bram_rdata;
                        mem_ack_q   <= 1'b1;
                        state_q     <= StAck;
                    end
                end
                StWriteAck, StAck: begin
                    mem_ack_q <= 1'b0;
                    state_q   <= StHold;
                end
                StHold: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Core read-valid pipeline mirrors the BRAM latency.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= core_grant;
            for (int i = 1; i < int'(C_MEM_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign core_rvalid      = vld_q[C_MEM_LATENCY-1];
    assign core_rdata       = core_rvalid ? bram_rdata : '0;
    assign mem_rdata        = mem_rdata_q;
    assign mem_ack          = mem_ack_q;
    assign contention_count = contention_q;

endmodule
